// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the multi-port register file.
package regfile_pkg;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 16;
    localparam int PC_IDX    = 15;
    localparam int PC_OFFSET = 8;
    localparam int ADDR_W    = $clog2(NUM_REGS);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t PC_ADDR = reg_addr_t'(PC_IDX);
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write busy bits: lock sets, writes clear, lock wins on collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_RD = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           lock_en_i,
    input  reg_addr_t                      lock_addr_i,
    input  logic                           clr_a_en_i,
    input  reg_addr_t                      clr_a_addr_i,
    input  logic                           clr_b_en_i,
    input  reg_addr_t                      clr_b_addr_i,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_i,
    output logic [NUM_RD-1:0]              busy_rd_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_RD-1:0]   busy_rd_q, busy_rd_d;

    // Addresses that match no register (out of range) never touch a bit.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (clr_a_en_i && clr_a_addr_i == reg_addr_t'(r)) busy_d[r] = 1'b0;
            if (clr_b_en_i && clr_b_addr_i == reg_addr_t'(r)) busy_d[r] = 1'b0;
            if (lock_en_i && lock_addr_i == reg_addr_t'(r) && r != PC_IDX) busy_d[r] = 1'b1;
        end
    end

    always_comb begin
        busy_rd_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rd_addr_i[k] == reg_addr_t'(r)) busy_rd_d[k] = busy_d[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            busy_rd_q <= '0;
        end else begin
            busy_q    <= busy_d;
            busy_rd_q <= busy_rd_d;
        end
    end

    assign busy_rd_o = busy_rd_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, registered write-first reads,
// an aliased PC register with redirect pulse, and a load scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int NUM_RD = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  i_addr_r,
    output logic [NUM_RD-1:0][DATA_W-1:0]  o_data_r,
    output logic [NUM_RD-1:0]              o_busy_r,
    input  logic                           i_wa_en,
    input  reg_addr_t                      i_wa_addr,
    input  word_t                          i_wa_data,
    input  logic                           i_wb_en,
    input  reg_addr_t                      i_wb_addr,
    input  word_t                          i_wb_data,
    input  logic                           i_lock_en,
    input  reg_addr_t                      i_lock_addr,
    input  word_t                          i_pc,
    input  logic                           i_pc_en,
    output word_t                          o_pc_r,
    output logic                           o_pc_redirect_r
);

    localparam int NUM_ENT = NUM_REGS - 1;

    // Array entries skip the PC slot.
    function automatic reg_addr_t ent_addr(input int e);
        return reg_addr_t'((e < PC_IDX) ? e : e + 1);
    endfunction

    word_t                         mem_q [NUM_ENT];
    word_t                         mem_d [NUM_ENT];
    word_t                         pc_q, pc_d;
    logic                          redirect_q, redirect_d;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_q, rd_data_d;
    logic                          wa_keep, pc_wr_a, pc_wr_b;

    assign wa_keep = i_wa_en && !(i_wb_en && i_wb_addr == i_wa_addr);
    assign pc_wr_a = wa_keep && i_wa_addr == PC_ADDR;
    assign pc_wr_b = i_wb_en && i_wb_addr == PC_ADDR;

    always_comb begin
        for (int e = 0; e < NUM_ENT; e++) begin
            mem_d[e] = mem_q[e];
            if (wa_keep && i_wa_addr == ent_addr(e)) mem_d[e] = i_wa_data;
            if (i_wb_en && i_wb_addr == ent_addr(e)) mem_d[e] = i_wb_data;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        redirect_d = pc_wr_a || pc_wr_b;
        if (pc_wr_b)      pc_d = i_wb_data;
        else if (pc_wr_a) pc_d = i_wa_data;
        else if (i_pc_en) pc_d = i_pc;
    end

    // Reads look at next-state values so a same-edge write is visible.
    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (i_addr_r[k] == PC_ADDR) rd_data_d[k] = pc_d + word_t'(PC_OFFSET);
            for (int e = 0; e < NUM_ENT; e++) begin
                if (i_addr_r[k] == ent_addr(e)) rd_data_d[k] = mem_d[e];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_ENT; e++) mem_q[e] <= '0;
            pc_q       <= '0;
            redirect_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            for (int e = 0; e < NUM_ENT; e++) mem_q[e] <= mem_d[e];
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            rd_data_q  <= rd_data_d;
        end
    end

    regfile_scoreboard #(.NUM_RD(NUM_RD)) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .lock_en_i    (i_lock_en),
        .lock_addr_i  (i_lock_addr),
        .clr_a_en_i   (i_wa_en),
        .clr_a_addr_i (i_wa_addr),
        .clr_b_en_i   (i_wb_en),
        .clr_b_addr_i (i_wb_addr),
        .rd_addr_i    (i_addr_r),
        .busy_rd_o    (o_busy_r)
    );

    assign o_data_r        = rd_data_q;
    assign o_pc_r          = pc_q;
    assign o_pc_redirect_r = redirect_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// against an architectural register/busy model.
module tb_regfile_mp;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][3:0]  addr_r;
    logic [2:0][31:0] data_r;
    logic [2:0]       busy_r;
    logic             wa_en, wb_en, lock_en, pc_en;
    logic [3:0]       wa_addr, wb_addr, lock_addr;
    logic [31:0]      wa_data, wb_data, pc_in;
    logic [31:0]      pc_r;
    logic             redirect_r;

    int checks = 0;
    int errors = 0;

    // Architectural model: index 15 is the PC.
    logic [31:0] m_reg  [16];
    logic        m_busy [16];
    logic        m_redirect;
    logic [31:0] exp_data [3];
    logic        exp_busy [3];

    always #5 clk = ~clk;

    regfile_mp #(.NUM_RD(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_addr_r        (addr_r),
        .o_data_r        (data_r),
        .o_busy_r        (busy_r),
        .i_wa_en         (wa_en),
        .i_wa_addr       (wa_addr),
        .i_wa_data       (wa_data),
        .i_wb_en         (wb_en),
        .i_wb_addr       (wb_addr),
        .i_wb_data       (wb_data),
        .i_lock_en       (lock_en),
        .i_lock_addr     (lock_addr),
        .i_pc            (pc_in),
        .i_pc_en         (pc_en),
        .o_pc_r          (pc_r),
        .o_pc_redirect_r (redirect_r)
    );

    task automatic clear_inputs();
        addr_r = '0; wa_en = 0; wb_en = 0; lock_en = 0; pc_en = 0;
        wa_addr = 0; wb_addr = 0; lock_addr = 0;
        wa_data = 0; wb_data = 0; pc_in = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_reg[i] = 0; m_busy[i] = 0;
        end
        m_redirect = 0;
    endtask

    task automatic model_step();
        logic redir;
        redir = (wa_en && wa_addr == 4'd15) || (wb_en && wb_addr == 4'd15);
        if (wa_en) m_reg[wa_addr] = wa_data;
        if (wb_en) m_reg[wb_addr] = wb_data;
        if (!redir && pc_en) m_reg[15] = pc_in;
        if (wa_en) m_busy[wa_addr] = 0;
        if (wb_en) m_busy[wb_addr] = 0;
        if (lock_en && lock_addr != 4'd15) m_busy[lock_addr] = 1;
        m_redirect = redir;
        for (int k = 0; k < 3; k++) begin
            exp_data[k] = (addr_r[k] == 4'd15) ? m_reg[15] + 32'd8 : m_reg[addr_r[k]];
            exp_busy[k] = m_busy[addr_r[k]];
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs(); model_reset();
        #1;
        checks++; if (data_r !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_r); end
        checks++; if (busy_r !== 3'b0) begin errors++; $display("FAIL reset_busy got=%b exp=000", busy_r); end
        checks++; if (pc_r !== 32'h0 || redirect_r !== 1'b0) begin errors++;
            $display("FAIL reset_pc got pc=%h redir=%b exp 0/0", pc_r, redirect_r); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_bypass();
        clear_inputs();
        wa_en = 1; wa_addr = 2; wa_data = 32'hDEADBEEF; addr_r[0] = 2;
        tick();
        checks++; if (data_r[0] !== 32'hDEADBEEF) begin errors++;
            $display("FAIL bypass_same_cycle got=%h exp=deadbeef", data_r[0]); end
        clear_inputs(); addr_r[1] = 2;
        tick();
        checks++; if (data_r[1] !== 32'hDEADBEEF) begin errors++;
            $display("FAIL read_next_cycle got=%h exp=deadbeef", data_r[1]); end
    endtask

    task automatic test_conflict();
        clear_inputs();
        wa_en = 1; wa_addr = 4; wa_data = 32'h11;
        wb_en = 1; wb_addr = 4; wb_data = 32'h22;
        addr_r = {4'd4, 4'd4, 4'd4};
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (data_r[k] !== 32'h22) begin errors++;
                $display("FAIL conflict_port%0d got=%h exp=22", k, data_r[k]); end
        end
    endtask

    task automatic test_pc();
        clear_inputs();
        pc_en = 1; pc_in = 32'h100; addr_r[0] = 15;
        tick();
        checks++; if (pc_r !== 32'h100) begin errors++; $display("FAIL pc_load got=%h exp=100", pc_r); end
        checks++; if (data_r[0] !== 32'h108) begin errors++; $display("FAIL pc_read got=%h exp=108", data_r[0]); end
        checks++; if (redirect_r !== 1'b0) begin errors++; $display("FAIL pc_no_redirect got=%b exp=0", redirect_r); end
        pc_in = 32'h104; wb_en = 1; wb_addr = 15; wb_data = 32'h400;
        tick();
        checks++; if (pc_r !== 32'h400) begin errors++; $display("FAIL pc_redirect_val got=%h exp=400", pc_r); end
        checks++; if (redirect_r !== 1'b1) begin errors++; $display("FAIL redirect_pulse got=%b exp=1", redirect_r); end
        checks++; if (data_r[0] !== 32'h408) begin errors++; $display("FAIL pc_read_redir got=%h exp=408", data_r[0]); end
        clear_inputs(); addr_r[0] = 15;
        tick();
        checks++; if (redirect_r !== 1'b0 || pc_r !== 32'h400) begin errors++;
            $display("FAIL redirect_end got redir=%b pc=%h exp 0/400", redirect_r, pc_r); end
    endtask

    task automatic test_scoreboard();
        clear_inputs();
        lock_en = 1; lock_addr = 5; addr_r[0] = 5;
        tick();
        checks++; if (busy_r[0] !== 1'b1) begin errors++; $display("FAIL lock_busy got=%b exp=1", busy_r[0]); end
        clear_inputs(); addr_r[0] = 5;
        wb_en = 1; wb_addr = 5; wb_data = 32'h55;
        tick();
        checks++; if (busy_r[0] !== 1'b0 || data_r[0] !== 32'h55) begin errors++;
            $display("FAIL write_clears got busy=%b data=%h exp 0/55", busy_r[0], data_r[0]); end
        clear_inputs(); addr_r[1] = 6;
        lock_en = 1; lock_addr = 6; wa_en = 1; wa_addr = 6; wa_data = 32'h66;
        tick();
        checks++; if (busy_r[1] !== 1'b1 || data_r[1] !== 32'h66) begin errors++;
            $display("FAIL lock_wins got busy=%b data=%h exp 1/66", busy_r[1], data_r[1]); end
    endtask

    task automatic test_wrap();
        clear_inputs();
        pc_en = 1; pc_in = 32'hFFFFFFFC; addr_r[0] = 15;
        tick();
        checks++; if (data_r[0] !== 32'h4) begin errors++; $display("FAIL pc_wrap got=%h exp=00000004", data_r[0]); end
        clear_inputs(); addr_r[0] = 15; lock_en = 1; lock_addr = 15;
        tick();
        checks++; if (busy_r[0] !== 1'b0) begin errors++; $display("FAIL pc_never_busy got=%b exp=0", busy_r[0]); end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        wa_en = 1; wa_addr = 3; wa_data = 32'h1234; lock_en = 1; lock_addr = 3;
        addr_r[0] = 3; pc_en = 1; pc_in = 32'h200;
        tick();
        checks++; if (data_r[0] !== 32'h1234 || busy_r[0] !== 1'b1) begin errors++;
            $display("FAIL pre_reset got data=%h busy=%b exp 1234/1", data_r[0], busy_r[0]); end
        clear_inputs(); addr_r[0] = 3;
        rst = 1;
        #1;
        checks++; if (data_r !== '0 || busy_r !== 3'b0 || pc_r !== 32'h0) begin errors++;
            $display("FAIL mid_reset got data=%h busy=%b pc=%h exp all 0", data_r, busy_r, pc_r); end
        model_reset();
        @(negedge clk);
        rst = 0;
        tick();
        checks++; if (data_r[0] !== 32'h0 || busy_r[0] !== 1'b0) begin errors++;
            $display("FAIL post_reset_r3 got data=%h busy=%b exp 0/0", data_r[0], busy_r[0]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++) addr_r[k] = 4'($urandom_range(0, 15));
            wa_en     = 1'($urandom_range(0, 1));
            wa_addr   = 4'($urandom_range(0, 15));
            wa_data   = $urandom;
            wb_en     = 1'($urandom_range(0, 1));
            wb_addr   = ($urandom_range(0, 3) == 0) ? wa_addr : 4'($urandom_range(0, 15));
            wb_data   = $urandom;
            lock_en   = 1'($urandom_range(0, 1));
            lock_addr = ($urandom_range(0, 3) == 0) ? wa_addr : 4'($urandom_range(0, 15));
            pc_en     = 1'($urandom_range(0, 1));
            pc_in     = $urandom;
            tick();
            checks++; if (pc_r !== m_reg[15]) begin errors++;
                $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", n, pc_r, m_reg[15]); end
            checks++; if (redirect_r !== m_redirect) begin errors++;
                $display("FAIL rnd_redirect cyc=%0d got=%b exp=%b", n, redirect_r, m_redirect); end
            for (int k = 0; k < 3; k++) begin
                checks++; if (data_r[k] !== exp_data[k]) begin errors++;
                    $display("FAIL rnd_data cyc=%0d port=%0d got=%h exp=%h", n, k, data_r[k], exp_data[k]); end
                checks++; if (busy_r[k] !== exp_busy[k]) begin errors++;
                    $display("FAIL rnd_busy cyc=%0d port=%0d got=%b exp=%b", n, k, busy_r[k], exp_busy[k]); end
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_conflict();
        test_pc();
        test_scoreboard();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the CPU core.
- Provides NUM_RD registered read ports, two write ports (A = ALU result, B = load writeback), and a dedicated PC register with redirect signalling.
- Includes a pending-write scoreboard with per-register busy bits, so decode can stall on outstanding loads.
- Sits between decode (read addresses, lock requests) and execute/writeback (write ports, PC update).

Parameters:
- DATA_W, 32, data word width.
- NUM_REGS, 16, architectural register count, including PC.
- NUM_RD, 3, number of read ports.
- PC_IDX, 15, index that aliases the PC register.
- PC_OFFSET, 8, value added to the PC when PC_IDX is read.
- ADDR_W, $clog2(NUM_REGS), derived; not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset.
- i_addr_r  in  NUM_RD x ADDR_W  read addresses, one per port.
- o_data_r  out  NUM_RD x DATA_W  registered read data.
- o_busy_r  out  NUM_RD  registered busy flag of each addressed register.
- i_wa_en  in  1  write port A enable.
- i_wa_addr  in  ADDR_W  write port A address.
- i_wa_data  in  DATA_W  write port A data.
- i_wb_en  in  1  write port B enable.
- i_wb_addr  in  ADDR_W  write port B address.
- i_wb_data  in  DATA_W  write port B data.
- i_lock_en  in  1  mark a register pending.
- i_lock_addr  in  ADDR_W  register to mark pending.
- i_pc  in  DATA_W  sequential next PC.
- i_pc_en  in  1  load i_pc into the PC register.
- o_pc_r  out  DATA_W  current PC.
- o_pc_redirect_r  out  1  one-cycle pulse after a write port targets PC_IDX.

Behaviour:
- Clocking and reset: single clock clk. Reset rst is asynchronous and active-high.
- While rst=1, all of the following are 0:
  - every array register and every busy bit;
  - o_data_r, o_busy_r, o_pc_r and o_pc_redirect_r.
- On the first edge after rst is released, normal operation begins.
- Array storage: NUM_REGS-1 entries; PC_IDX is not stored in the array.
- Write priority: if A and B are enabled to the same address on the same edge, B wins and A is dropped.
- Out-of-range addresses (addr >= NUM_REGS):
  - writes are ignored;
  - reads return 0 with busy=0;
  - lock is ignored.
- PC register:
  - A write from port A or B to PC_IDX loads the PC and overrides i_pc_en. o_pc_redirect_r=1 for exactly the following cycle.
  - Otherwise, i_pc_en=1 loads i_pc.
  - Otherwise the PC holds.
- Reads:
  - Latency is 1 cycle.
  - o_data_r[k] after edge t = contents of register i_addr_r[k] after all writes at edge t (write-first bypass). A same-cycle write is therefore visible without an extra cycle.
  - A read of PC_IDX returns the updated PC + PC_OFFSET, modulo 2^DATA_W.
- Scoreboard:
  - i_lock_en sets busy[i_lock_addr].
  - A write via A or B clears busy[addr].
  - Lock and write to the same address on the same edge: lock wins, busy=1. The write data is still stored.
  - Lock of PC_IDX is ignored; PC is never busy.
  - o_busy_r[k] reflects the busy bit after the edge's update, consistent with the bypass.
- Arithmetic: PC + PC_OFFSET wraps at DATA_W bits; no saturation.
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Package regfile_pkg holds:
  - constants DATA_W, NUM_REGS, PC_IDX, PC_OFFSET, ADDR_W;
  - typedefs word_t (logic [DATA_W-1:0]) and reg_addr_t (logic [ADDR_W-1:0]).
- One sub-module, regfile_scoreboard, owns:
  - the NUM_REGS busy bits;
  - the lock/clear priority;
  - the NUM_RD registered busy lookups.
- The top level holds the array, write arbitration, the PC and the read bypass.

Test Plan:
- Reset: assert rst mid-operation with r3=0x1234 and r3 busy -> same cycle o_data_r=0, o_busy_r=0, o_pc_r=0; after release, a read of r3 returns 0.
- Basic write/read and bypass:
  - write A r2=0xDEADBEEF at edge t, with i_addr_r[0]=2 on the same cycle -> o_data_r[0]=0xDEADBEEF after edge t;
  - port 1 reading r2 one cycle later also sees 0xDEADBEEF.
- Write conflict: A r4=0x11 and B r4=0x22 on the same edge -> r4 reads 0x22 on all ports.
- PC handling:
  - i_pc_en=1, i_pc=0x100 -> o_pc_r=0x100, and a read of r15 returns 0x108;
  - same cycle, B writes r15=0x400 with i_pc=0x104 -> o_pc_r=0x400, o_pc_redirect_r=1 for one cycle only.
- Scoreboard:
  - lock r5 -> o_busy_r=1 while r5 is addressed;
  - B writes r5=0x55 -> next cycle busy=0, data=0x55;
  - lock and write r6 on the same edge -> busy=1, data updated.
- Wrap: PC=0xFFFFFFFC, read r15 -> 0x00000004; lock r15 -> busy stays 0.
